// File: rtl/nibble_demux_loader.sv
// Nibble demultiplexer for manual SAP-1 RAM programming: routes address nibbles to the
// address register and packs data nibble pairs into bytes, strobing one RAM write per byte.
module nibble_demux_loader #(
    parameter bit         AUTO_INC   = 1'b1,
    parameter logic [3:0] ADDR_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       select,
    input  logic [3:0] in_data,
    output logic [3:0] addr_out,
    output logic [7:0] data_out,
    output logic       wr_en,
    output logic       resync
);

    typedef enum logic [1:0] {
        StWaitHi = 2'd0,
        StWaitLo = 2'd1,
        StWrite  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wr_en_q, wr_en_d;
    logic       resync_q, resync_d;
    logic       xfer;

    // Gated by clr_n so the source sees no acceptance while reset is held.
    assign in_ready = clr_n && (state_q != StWrite);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_en_d  = 1'b0;
        resync_d = 1'b0;
        case (state_q)
            StWaitHi: begin
                if (xfer) begin
                    if (select) begin
                        addr_d = in_data;
                    end else begin
                        hi_d    = in_data;
                        state_d = StWaitLo;
                    end
                end
            end
            StWaitLo: begin
                if (xfer) begin
                    if (select) begin
                        // Address mid-pair: the held high nibble is stale, drop it.
                        addr_d   = in_data;
                        hi_d     = 4'h0;
                        resync_d = 1'b1;
                        state_d  = StWaitHi;
                    end else begin
                        data_d  = {hi_q, in_data};
                        wr_en_d = 1'b1;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                state_d = StWaitHi;
                if (AUTO_INC) begin
                    addr_d = addr_q + 4'd1;
                end
            end
            default: begin
                state_d = StWaitHi;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= StWaitHi;
            hi_q     <= 4'h0;
            addr_q   <= ADDR_RESET;
            data_q   <= 8'h00;
            wr_en_q  <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
            resync_q <= resync_d;
        end
    end

    assign addr_out = addr_q;
    assign data_out = data_q;
    assign wr_en    = wr_en_q;
    assign resync   = resync_q;

    wr_en_single_a: assert property (@(posedge clk) disable iff (!clr_n) wr_en |=> !wr_en);
    resync_single_a: assert property (@(posedge clk) disable iff (!clr_n) resync |=> !resync);
    wr_not_ready_a: assert property (@(posedge clk) disable iff (!clr_n) wr_en |-> !in_ready);
    wr_resync_excl_a: assert property (@(posedge clk) disable iff (!clr_n) !(wr_en && resync));

endmodule
